// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_tx_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
interface uart_tx_ctrl_if import uart_tx_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  par_bit;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, par_bit,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, par_bit,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_serializer.sv
// Shift register and bit counter; ser_data is the bit the line carries after this edge.
module uart_serializer import uart_tx_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  ser_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_data,
  output logic                  ser_done
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  assign w_shift_nxt = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_shift <= data;
      r_cnt   <= '0;
    end else if (ser_en) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
    end
  end

  // While shifting, the next line bit is the one about to move into position 0.
  assign ser_data = ser_en ? w_shift_nxt[0] : r_shift[0];
  assign ser_done = (r_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM and registered line/busy outputs.
module uart_tx_ctrl import uart_tx_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_ctrl_if.slave  bus
);
  tx_state_e r_state;
  tx_state_e w_state_next;
  logic      r_tx;
  logic      r_busy;
  logic      r_par_en_q;
  logic      w_tx_next;
  logic      w_busy_next;
  logic      w_accept;
  logic      w_load;
  logic      w_ser_en;
  logic      w_ser_data;
  logic      w_ser_done;

  uart_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .ser_en   (w_ser_en),
    .data     (bus.P_DATA),
    .ser_data (w_ser_data),
    .ser_done (w_ser_done)
  );

  // Same qualification parity_calc uses, so both capture the same byte.
  assign w_accept = bus.Data_Valid && !r_busy && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_par_en_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      if (w_accept) r_par_en_q <= bus.PAR_EN;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;
    w_load       = 1'b0;
    w_ser_en     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next   = IDLE_LEVEL;
        w_busy_next = 1'b0;
        if (w_accept) begin
          w_state_next = START;
          w_tx_next    = START_BIT;
          w_busy_next  = 1'b1;
          w_load       = 1'b1;
        end
      end
      START: begin
        w_state_next = DATA;
        w_tx_next    = w_ser_data;
      end
      DATA: begin
        w_ser_en = 1'b1;
        if (w_ser_done) begin
          if (r_par_en_q) begin
            w_state_next = PARITY;
            w_tx_next    = bus.par_bit;
          end else begin
            w_state_next = STOP;
            w_tx_next    = STOP_BIT;
          end
        end else begin
          w_tx_next = w_ser_data;
        end
      end
      PARITY: begin
        w_state_next = STOP;
        w_tx_next    = STOP_BIT;
      end
      STOP: begin
        w_state_next = IDLE;
        w_tx_next    = IDLE_LEVEL;
        w_busy_next  = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = IDLE_LEVEL;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with an even-parity parity_calc stand-in on the side.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] line;
  int          nbits;
  int          lead;
  bit          tmo;
  logic        idle_tx;

  logic [7:0]  pc_data;
  logic        pc_stage;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // parity_calc stand-in: capture on accept, parity registered two edges later.
  always @(posedge clk) begin
    if (!rst_n) begin
      pc_data     <= 8'h00;
      pc_stage    <= 1'b0;
      bus.par_bit <= 1'b0;
    end else begin
      if (bus.Data_Valid && !bus.busy) pc_data <= bus.P_DATA;
      pc_stage    <= ^pc_data;
      bus.par_bit <= pc_stage;
    end
  end

  // Expected line bits: start, data LSB first, optional even parity, stop.
  function automatic void model_frame(input logic [7:0] d, input bit pe,
                                      output logic [15:0] exp_line, output int len);
    exp_line = '0;
    exp_line[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_line[1 + i] = d[i];
    len = 9;
    if (pe) begin
      exp_line[len] = ^d;
      len++;
    end
    exp_line[len] = 1'b1;
    len++;
  endfunction

  task automatic send(input logic [7:0] d, input bit pe, input bit hold);
    @(negedge clk);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.Data_Valid = 1'b0;
  endtask

  // Records the line while busy; returns at the first idle sample after the frame.
  task automatic observe_frame();
    line = '0; nbits = 0; lead = 0; tmo = 1'b1; idle_tx = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        if (nbits < 16) line[nbits] = bus.TX_OUT;
        nbits++;
      end else if (nbits > 0) begin
        tmo = 1'b0;
        idle_tx = bus.TX_OUT;
        break;
      end else begin
        lead++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA = 8'h00;
    bus.PAR_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.TX_OUT !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", bus.TX_OUT); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_cycle%0d: got tx=%b busy=%b expected tx=1 busy=0", c, bus.TX_OUT, bus.busy);
      end
    end
  endtask

  task automatic test_parity_frame();
    send(8'hA5, 1'b1, 1'b0);
    observe_frame();
    n_cmp++;
    if (tmo) begin n_err++; $display("FAIL a5_timeout: busy never returned low"); end
    n_cmp++;
    if (nbits != 11) begin n_err++; $display("FAIL a5_busy_len: got %0d expected 11", nbits); end
    n_cmp++;
    if (line !== 16'h054A) begin n_err++; $display("FAIL a5_line: got %h expected 054a", line); end
    n_cmp++;
    if (idle_tx !== 1'b1) begin n_err++; $display("FAIL a5_idle_after: got %b expected 1", idle_tx); end
  endtask

  task automatic test_no_parity();
    send(8'h01, 1'b0, 1'b0);
    observe_frame();
    n_cmp++;
    if (tmo || nbits != 10) begin n_err++; $display("FAIL np_busy_len: got %0d (tmo=%0b) expected 10", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h0202) begin n_err++; $display("FAIL np_line: got %h expected 0202", line); end
    send(8'h01, 1'b1, 1'b0);
    observe_frame();
    n_cmp++;
    if (tmo || nbits != 11) begin n_err++; $display("FAIL p01_busy_len: got %0d (tmo=%0b) expected 11", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h0602) begin n_err++; $display("FAIL p01_line: got %h expected 0602", line); end
  endtask

  task automatic test_ignored_strobe();
    int late_busy;
    send(8'h3C, 1'b1, 1'b0);
    fork
      observe_frame();
      begin
        repeat (4) @(negedge clk);
        bus.P_DATA = 8'hFF;
        bus.PAR_EN = 1'b0;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
      end
    join
    n_cmp++;
    if (tmo || nbits != 11) begin n_err++; $display("FAIL ign_busy_len: got %0d (tmo=%0b) expected 11", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h0478) begin n_err++; $display("FAIL ign_line: got %h expected 0478", line); end
    late_busy = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) late_busy++;
    end
    n_cmp++;
    if (late_busy != 0) begin n_err++; $display("FAIL ign_no_ff_frame: got %0d busy cycles expected 0", late_busy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.P_DATA = 8'h55;
    bus.PAR_EN = 1'b1;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.P_DATA = 8'hAA;
    observe_frame();
    n_cmp++;
    if (tmo || nbits != 11) begin n_err++; $display("FAIL b2b1_busy_len: got %0d (tmo=%0b) expected 11", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h04AA) begin n_err++; $display("FAIL b2b1_line: got %h expected 04aa", line); end
    n_cmp++;
    if (idle_tx !== 1'b1) begin n_err++; $display("FAIL b2b_gap_level: got %b expected 1", idle_tx); end
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
    observe_frame();
    n_cmp++;
    if (lead != 0) begin n_err++; $display("FAIL b2b_gap_len: got %0d extra idle cycles expected 0", lead); end
    n_cmp++;
    if (tmo || nbits != 11) begin n_err++; $display("FAIL b2b2_busy_len: got %0d (tmo=%0b) expected 11", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h0554) begin n_err++; $display("FAIL b2b2_line: got %h expected 0554", line); end
  endtask

  task automatic test_reset_mid_frame();
    send(8'hC3, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got tx=%b busy=%b expected tx=1 busy=0", bus.TX_OUT, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after: got tx=%b busy=%b expected tx=1 busy=0", bus.TX_OUT, bus.busy);
    end
    send(8'h81, 1'b1, 1'b0);
    observe_frame();
    n_cmp++;
    if (tmo || nbits != 11) begin n_err++; $display("FAIL r81_busy_len: got %0d (tmo=%0b) expected 11", nbits, tmo); end
    n_cmp++;
    if (line !== 16'h0502) begin n_err++; $display("FAIL r81_line: got %h expected 0502", line); end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    bit          pe;
    logic [15:0] exp_line;
    int          exp_len;
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, pe, 1'b0);
      bus.P_DATA = 8'($urandom);
      bus.PAR_EN = 1'($urandom_range(0, 1));
      model_frame(d, pe, exp_line, exp_len);
      observe_frame();
      n_cmp++;
      if (tmo || lead != 0 || nbits != exp_len) begin
        n_err++;
        $display("FAIL rnd%0d_len: data=%h pe=%0b got %0d bits (lead=%0d tmo=%0b) expected %0d",
                 i, d, pe, nbits, lead, tmo, exp_len);
      end
      n_cmp++;
      if (line !== exp_line || idle_tx !== 1'b1) begin
        n_err++;
        $display("FAIL rnd%0d_line: data=%h pe=%0b got %h idle=%b expected %h idle=1",
                 i, d, pe, line, idle_tx, exp_line);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_ignored_strobe();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller and serializer. It sits directly downstream of parity_calc and drives the serial line.
- Accepts a parallel byte with a valid strobe.
- Frames it as start bit, data bits (LSB first), optional parity bit and stop bit, one bit per clk.
- Exports busy, which parity_calc uses to gate its own data capture.
- Consumes par_bit from parity_calc to fill the parity slot.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; the bit counter is $clog2(DATA_WIDTH) wide.

Ports:
clk  input  1  system clock; one serial bit per cycle
rst_n  input  1  reset, synchronous, active-low
P_DATA  input  DATA_WIDTH  parallel byte to transmit
Data_Valid  input  1  P_DATA valid; accepted only when busy=0
PAR_EN  input  1  parity slot enable; sampled at accept
par_bit  input  1  parity bit from parity_calc; sampled on entry to PARITY
TX_OUT  output  1  serial line; idles high
busy  output  1  high while a frame is on the line

Behaviour:
- Reset: synchronous; at a clk edge with rst_n=0:
  - state=IDLE, TX_OUT=1, busy=0
  - shift register=0, bit counter=0, par_en_q=0
  - Applies mid-frame: the frame is aborted and the line returns high on that edge.
- Outputs: TX_OUT and busy are registered and change on the same edge as state.
- Accept condition is Data_Valid && !busy, identical to parity_calc's capture condition. On accept:
  - P_DATA goes into the shift register and PAR_EN into par_en_q.
  - state goes to START, TX_OUT<=0, busy<=1.
- Data_Valid while busy=1 is ignored. There is no buffering and no error flag.
- States:
  - IDLE: TX_OUT=1, busy=0. Goes to START on accept.
  - START: one cycle at TX_OUT=0. Then DATA, with TX_OUT<=shift[0] and counter=0.
  - DATA: each edge shifts right and increments the counter. TX_OUT carries bit i during the i-th DATA cycle.
    - On the edge leaving the counter=DATA_WIDTH-1 cycle:
      - if par_en_q=1, go to PARITY with TX_OUT<=par_bit;
      - otherwise go to STOP with TX_OUT<=1.
  - PARITY: one cycle. Then STOP with TX_OUT<=1.
  - STOP: one cycle at TX_OUT=1, busy=1. Then IDLE with busy<=0.
- Timing:
  - busy is high for 11 cycles with parity and 10 without (DATA_WIDTH=8).
  - At least one IDLE cycle falls between frames, so minimum accept-to-accept spacing is 12 or 11 cycles.
- par_bit is stable by the PARITY sample point: parity_calc registers it two edges after accept.
- PAR_EN or P_DATA changing mid-frame has no effect on the current frame.
- The counter wraps to 0 on leaving DATA. Counter overflow is impossible by construction.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1;
  - the default DATA_WIDTH.
- One sub-module, uart_serializer, holds the shift register and bit counter.
  - Inputs: load, ser_en, data.
  - Outputs: ser_data, ser_done.
- The top level keeps the FSM and the output mux.

Test Plan:
The bench instantiates parity_calc beside the DUT, with busy fed back to it and par_type=1 (even).
1. Reset, then idle: hold rst_n=0 for 2 cycles, then release -> TX_OUT=1 and busy=0 for 20 cycles with no Data_Valid.
2. Parity frame: P_DATA=0xA5, PAR_EN=1, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. busy=1 for exactly 11 cycles, then 0.
3. No-parity frame: P_DATA=0x01, PAR_EN=0 -> TX_OUT sequence 0,1,0,0,0,0,0,0,0,1. busy high 10 cycles. Rerun with PAR_EN=1 -> parity slot is 1.
4. Ignored strobe: Data_Valid pulsed with 0xFF at cycle 4 of a 0x3C frame -> 0x3C frame is unchanged; 0xFF is never sent; parity_calc still reflects 0x3C.
5. Back-to-back: Data_Valid held high with 0x55 then 0xAA -> second start bit appears exactly one IDLE cycle after the first stop bit; both frames are correct.
6. Reset mid-frame: rst_n=0 during DATA bit 3 -> next edge TX_OUT=1, busy=0. A subsequent 0x81 frame is correct.
